// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS core: ISA encodings, FSM states,
// ALU control codes and small decode helpers.
package mips_mc_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        logic ok;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
                    default:                               ok = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Non-R-type instructions only ever need an add (addi and address generation).
    function automatic alu_op_t alu_ctrl(input logic [5:0] op, input logic [5:0] funct);
        alu_op_t ctrl;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_SUB:  ctrl = ALU_SUB;
                FN_AND:  ctrl = ALU_AND;
                FN_OR:   ctrl = ALU_OR;
                FN_SLT:  ctrl = ALU_SLT;
                default: ctrl = ALU_ADD;
            endcase
        end else begin
            ctrl = ALU_ADD;
        end
        return ctrl;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// register 0 hardwired to zero.
module mc_regfile
    import mips_mc_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2
);

    logic [31:0] regs_r [0:31];

    // Write port; writes to register 0 are dropped.
    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs_r[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs_r[raddr2];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core with a single shared ALU, one register file and one
// req/ready memory port used for both instruction fetch and data access.
module mips_multicycle_core
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          ADDR_W          = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ready_i,
    output logic [31:0]       pc_o,
    output logic              retire_o,
    output logic              halt_o,
    output logic              illegal_o
);

    state_t              state_r;
    logic [31:0]         pc_r;
    logic [31:0]         ir_r;
    logic [31:0]         a_r;
    logic [31:0]         b_r;
    logic [31:0]         alu_out_r;
    logic [31:0]         mdr_r;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [31:0]         mem_wdata_r;
    logic                retire_r;
    logic                halt_r;
    logic                illegal_r;

    logic [5:0]          op_s;
    logic [5:0]          funct_s;
    logic [4:0]          rs_s;
    logic [4:0]          rt_s;
    logic [4:0]          rd_s;
    logic [31:0]         imm_s;
    logic                legal_s;
    logic [31:0]         rs_data_s;
    logic [31:0]         rt_data_s;
    logic [31:0]         alu_b_s;
    logic [31:0]         alu_res_s;
    logic [31:0]         pc_plus4_s;
    logic [31:0]         branch_target_s;
    logic [31:0]         jump_target_s;
    logic                retire_s;
    logic [31:0]         retire_pc_s;
    logic [ADDR_W-1:0]   fetch_addr_s;
    logic [ADDR_W-1:0]   data_addr_s;
    logic [ADDR_W-1:0]   retire_addr_s;
    logic                rf_we_s;
    logic [4:0]          rf_waddr_s;
    logic [31:0]         rf_wdata_s;

    assign op_s    = ir_r[31:26];
    assign rs_s    = ir_r[25:21];
    assign rt_s    = ir_r[20:16];
    assign rd_s    = ir_r[15:11];
    assign funct_s = ir_r[5:0];
    assign imm_s   = sext16(ir_r[15:0]);
    assign legal_s = is_legal(op_s, funct_s);

    // pc_r already holds PC+4 once DECODE has run, so targets are relative to it.
    assign pc_plus4_s      = pc_r + 32'd4;
    assign branch_target_s = pc_r + {imm_s[29:0], 2'b00};
    assign jump_target_s   = {pc_r[31:28], ir_r[25:0], 2'b00};

    assign fetch_addr_s  = {pc_r[ADDR_W-1:2], 2'b00};
    assign data_addr_s   = {alu_res_s[ADDR_W-1:2], 2'b00};
    assign retire_addr_s = {retire_pc_s[ADDR_W-1:2], 2'b00};

    assign rf_we_s    = (state_r == ST_WB) && !rst_i;
    assign rf_waddr_s = (op_s == OP_RTYPE) ? rd_s : rt_s;
    assign rf_wdata_s = (op_s == OP_LW) ? mdr_r : alu_out_r;

    mc_regfile u_regfile (
        .clk    (clk_i),
        .we     (rf_we_s),
        .waddr  (rf_waddr_s),
        .wdata  (rf_wdata_s),
        .raddr1 (rs_s),
        .rdata1 (rs_data_s),
        .raddr2 (rt_s),
        .rdata2 (rt_data_s)
    );

    // Shared ALU: second operand is B for R-type, sign-extended immediate otherwise.
    always_comb begin
        alu_b_s   = (op_s == OP_RTYPE) ? b_r : imm_s;
        alu_res_s = 32'd0;
        case (alu_ctrl(op_s, funct_s))
            ALU_ADD: alu_res_s = a_r + alu_b_s;
            ALU_SUB: alu_res_s = a_r - alu_b_s;
            ALU_AND: alu_res_s = a_r & alu_b_s;
            ALU_OR:  alu_res_s = a_r | alu_b_s;
            ALU_SLT: alu_res_s = {31'd0, ($signed(a_r) < $signed(alu_b_s))};
            default: alu_res_s = a_r + alu_b_s;
        endcase
    end

    // Instruction-boundary detection and the PC each retiring instruction leaves behind.
    always_comb begin
        retire_s    = 1'b0;
        retire_pc_s = pc_r;
        case (state_r)
            ST_DECODE: begin
                retire_s    = !legal_s && !HALT_ON_ILLEGAL;
                retire_pc_s = pc_plus4_s;
            end
            ST_EXEC: begin
                if (op_s == OP_BEQ) begin
                    retire_s    = 1'b1;
                    retire_pc_s = (a_r == b_r) ? branch_target_s : pc_r;
                end else if (op_s == OP_J) begin
                    retire_s    = 1'b1;
                    retire_pc_s = jump_target_s;
                end else begin
                    retire_s    = 1'b0;
                    retire_pc_s = pc_r;
                end
            end
            ST_MEM:  retire_s = mem_ready_i && (op_s == OP_SW);
            ST_WB:   retire_s = 1'b1;
            default: retire_s = 1'b0;
        endcase
    end

    // Control FSM with registered memory-port and status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_PC;
            ir_r        <= 32'd0;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            alu_out_r   <= 32'd0;
            mdr_r       <= 32'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'd0;
            retire_r    <= 1'b0;
            halt_r      <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            retire_r <= retire_s;
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        state_r    <= ST_FETCH;
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= fetch_addr_s;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready_i) begin
                        ir_r      <= mem_rdata_i;
                        mem_req_r <= 1'b0;
                        state_r   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    a_r  <= rs_data_s;
                    b_r  <= rt_data_s;
                    pc_r <= pc_plus4_s;
                    if (legal_s) begin
                        state_r <= ST_EXEC;
                    end else if (HALT_ON_ILLEGAL) begin
                        state_r   <= ST_HALT;
                        halt_r    <= 1'b1;
                        illegal_r <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    alu_out_r <= alu_res_s;
                    case (op_s)
                        OP_RTYPE, OP_ADDI: state_r <= ST_WB;
                        OP_LW, OP_SW: begin
                            state_r     <= ST_MEM;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= (op_s == OP_SW);
                            mem_addr_r  <= data_addr_s;
                            mem_wdata_r <= b_r;
                        end
                        OP_BEQ, OP_J: state_r <= ST_EXEC;
                        default: begin
                            state_r <= ST_HALT;
                            halt_r  <= 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready_i) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        mdr_r     <= mem_rdata_i;
                        if (op_s == OP_LW) begin
                            state_r <= ST_WB;
                        end
                    end
                end
                ST_WB: state_r <= ST_WB;
                ST_HALT: begin
                    state_r <= ST_HALT;
                    halt_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_HALT;
                    halt_r  <= 1'b1;
                end
            endcase
            // start_i is only sampled here, so a paused core finishes its instruction first.
            if (retire_s) begin
                pc_r <= retire_pc_s;
                if (start_i) begin
                    state_r    <= ST_FETCH;
                    mem_req_r  <= 1'b1;
                    mem_we_r   <= 1'b0;
                    mem_addr_r <= retire_addr_s;
                end else begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            end
        end
    end

    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign pc_o        = pc_r;
    assign retire_o    = retire_r;
    assign halt_o      = halt_r;
    assign illegal_o   = illegal_r;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: wait-state memory model with a
// store scoreboard, retire/PC logging and one task per scenario.
`timescale 1ns/1ps
module tb_mips_multicycle_core;

    localparam logic [31:0] ILLEGAL_OP = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        mem_ready_i = 1'b0;
    logic [31:0] pc_o;
    logic        retire_o;
    logic        halt_o;
    logic        illegal_o;

    always #5 clk = ~clk;

    mips_multicycle_core #(
        .RESET_PC        (32'h0000_0000),
        .ADDR_W          (32),
        .HALT_ON_ILLEGAL (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i),
        .pc_o        (pc_o),
        .retire_o    (retire_o),
        .halt_o      (halt_o),
        .illegal_o   (illegal_o)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem [0:1023];
    int          wait_states = 0;
    int          wcnt = 0;
    int          cyc = 0;
    int          first_fetch = -1;
    int          retire_log[$];
    logic [31:0] retire_pc_log[$];
    logic [63:0] exp_writes[$];
    logic        waiting_prev = 1'b0;
    logic        was_ready;
    logic [31:0] held_addr;
    logic [31:0] held_wdata;
    logic        held_we;
    logic [63:0] exp_w;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    // Memory model: wait states, handshake stability check, store scoreboard, retire log.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (retire_o === 1'b1) begin
            retire_log.push_back(cyc);
            retire_pc_log.push_back(pc_o);
        end
        if (mem_req_o === 1'b1 && first_fetch < 0) first_fetch = cyc;
        if (waiting_prev && mem_req_o === 1'b1) begin
            checks++;
            if (mem_addr_o !== held_addr || mem_we_o !== held_we || mem_wdata_o !== held_wdata) begin
                failures++;
                $display("FAIL hold_stable: addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                         mem_addr_o, mem_we_o, mem_wdata_o, held_addr, held_we, held_wdata);
            end
        end
        was_ready   = mem_ready_i;
        mem_ready_i = 1'b0;
        if (was_ready || mem_req_o !== 1'b1) wcnt = 0;
        waiting_prev = 1'b0;
        if (mem_req_o === 1'b1) begin
            held_addr  = mem_addr_o;
            held_we    = mem_we_o;
            held_wdata = mem_wdata_o;
            if (wcnt >= wait_states) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = mem[mem_addr_o[11:2]];
                if (mem_we_o === 1'b1) begin
                    mem[mem_addr_o[11:2]] = mem_wdata_o;
                    checks++;
                    if (exp_writes.size() == 0) begin
                        failures++;
                        $display("FAIL store_unexpected: addr=%h data=%h required no store", mem_addr_o, mem_wdata_o);
                    end else begin
                        exp_w = exp_writes.pop_front();
                        if ({mem_addr_o, mem_wdata_o} !== exp_w) begin
                            failures++;
                            $display("FAIL store: addr=%h data=%h required addr=%h data=%h",
                                     mem_addr_o, mem_wdata_o, exp_w[63:32], exp_w[31:0]);
                        end
                    end
                end
            end else begin
                wcnt++;
                waiting_prev = 1'b1;
            end
        end
    end

    task automatic begin_test(input int ws);
        rst_i   = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wait_states = ws;
        for (int i = 0; i < 1024; i++) mem[i] = ILLEGAL_OP;
        retire_log.delete();
        retire_pc_log.delete();
        exp_writes.delete();
        first_fetch = -1;
    endtask

    task automatic test_reset;
        begin_test(0);
        @(negedge clk);
        checks++;
        if ({mem_req_o, mem_we_o, retire_o, halt_o, illegal_o} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_flags: req/we/retire/halt/illegal=%b required 00000",
                     {mem_req_o, mem_we_o, retire_o, halt_o, illegal_o});
        end
        checks++;
        if (mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_bus: addr=%h wdata=%h required 0 0", mem_addr_o, mem_wdata_o);
        end
        checks++;
        if (pc_o !== 32'h0000_0000) begin
            failures++;
            $display("FAIL reset_pc: pc=%h required 00000000", pc_o);
        end
        rst_i = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b0 || pc_o !== 32'd0) begin
            failures++;
            $display("FAIL idle_no_start: req=%b pc=%h required 0 00000000", mem_req_o, pc_o);
        end
    endtask

    task automatic test_alu;
        logic [31:0] prog[$];
        begin_test(0);
        prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd5), enc_i(6'h08, 5'd0, 5'd2, 16'd7),
                 enc_r(5'd1, 5'd2, 5'd3, 6'h20), enc_r(5'd1, 5'd2, 5'd5, 6'h22),
                 enc_r(5'd5, 5'd1, 5'd6, 6'h2A), enc_r(5'd1, 5'd5, 5'd7, 6'h2A),
                 enc_r(5'd1, 5'd2, 5'd8, 6'h24), enc_r(5'd1, 5'd2, 5'd9, 6'h25),
                 enc_i(6'h08, 5'd0, 5'd10, 16'hFFFF), enc_r(5'd10, 5'd10, 5'd11, 6'h20),
                 enc_i(6'h2B, 5'd0, 5'd3, 16'h0080), enc_i(6'h2B, 5'd0, 5'd5, 16'h0084),
                 enc_i(6'h2B, 5'd0, 5'd6, 16'h0088), enc_i(6'h2B, 5'd0, 5'd7, 16'h008C),
                 enc_i(6'h2B, 5'd0, 5'd8, 16'h0090), enc_i(6'h2B, 5'd0, 5'd9, 16'h0094),
                 enc_i(6'h2B, 5'd0, 5'd11, 16'h0098), enc_r(5'd0, 5'd0, 5'd0, 6'h00)};
        foreach (prog[i]) mem[i] = prog[i];
        exp_writes = '{{32'h80, 32'd12}, {32'h84, 32'hFFFF_FFFE}, {32'h88, 32'd1},
                       {32'h8C, 32'd0}, {32'h90, 32'd5}, {32'h94, 32'd7},
                       {32'h98, 32'hFFFF_FFFE}};
        rst_i   = 1'b0;
        start_i = 1'b1;
        for (int i = 0; i < 300 && halt_o !== 1'b1; i++) @(negedge clk);
        checks++;
        if (halt_o !== 1'b1 || illegal_o !== 1'b1) begin
            failures++;
            $display("FAIL alu_halt: halt=%b illegal=%b required 1 1", halt_o, illegal_o);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (retire_log.size() <= k || retire_log[k] - first_fetch !== (k + 1) * 4) begin
                failures++;
                $display("FAIL alu_retire_cycle%0d: got=%0d required %0d", k,
                         (retire_log.size() > k) ? retire_log[k] - first_fetch : -1, (k + 1) * 4);
            end
        end
        checks++;
        if (retire_log.size() !== 17 || pc_o !== 32'h48) begin
            failures++;
            $display("FAIL alu_end: retires=%0d pc=%h required 17 00000048", retire_log.size(), pc_o);
        end
        checks++;
        if (exp_writes.size() !== 0) begin
            failures++;
            $display("FAIL alu_pending: stores left=%0d required 0", exp_writes.size());
        end
    endtask

    task automatic test_mem_wait;
        begin_test(2);
        mem[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd12);
        mem[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0040);
        mem[2] = enc_i(6'h23, 5'd0, 5'd4, 16'h0040);
        mem[3] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0044);
        exp_writes = '{{32'h40, 32'd12}, {32'h44, 32'd12}};
        rst_i   = 1'b0;
        start_i = 1'b1;
        for (int i = 0; i < 300 && halt_o !== 1'b1; i++) @(negedge clk);
        checks++;
        if (halt_o !== 1'b1 || retire_log.size() !== 4) begin
            failures++;
            $display("FAIL wait_end: halt=%b retires=%0d required 1 4", halt_o, retire_log.size());
        end
        checks++;
        if (retire_log.size() < 3 || retire_log[1] - retire_log[0] !== 8 || retire_log[2] - retire_log[1] !== 9) begin
            failures++;
            $display("FAIL wait_latency: sw=%0d lw=%0d required 8 9",
                     (retire_log.size() > 1) ? retire_log[1] - retire_log[0] : -1,
                     (retire_log.size() > 2) ? retire_log[2] - retire_log[1] : -1);
        end
        checks++;
        if (mem[16] !== 32'd12) begin
            failures++;
            $display("FAIL wait_mem40: got=%h required 0000000c", mem[16]);
        end
        checks++;
        if (exp_writes.size() !== 0) begin
            failures++;
            $display("FAIL wait_pending: stores left=%0d required 0", exp_writes.size());
        end
    endtask

    task automatic test_branch;
        logic [31:0] exp_pc[$];
        int          exp_gap[$];
        begin_test(0);
        mem[0]   = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
        mem[1]   = enc_i(6'h04, 5'd1, 5'd0, 16'd5);
        mem[2]   = enc_j(26'h100);
        mem[256] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0060);
        mem[257] = enc_j(26'h4);
        mem[4]   = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
        exp_writes = '{{32'h60, 32'd3}};
        exp_pc  = '{32'h4, 32'h8, 32'h400, 32'h404, 32'h10, 32'h10, 32'h10};
        exp_gap = '{0, 3, 3, 4, 3, 3, 3};
        rst_i   = 1'b0;
        start_i = 1'b1;
        for (int i = 0; i < 300 && retire_log.size() < 7; i++) @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (retire_pc_log.size() <= k || retire_pc_log[k] !== exp_pc[k]) begin
                failures++;
                $display("FAIL branch_pc%0d: got=%h required %h", k,
                         (retire_pc_log.size() > k) ? retire_pc_log[k] : 32'hDEAD_DEAD, exp_pc[k]);
            end
        end
        for (int k = 1; k < 7; k++) begin
            checks++;
            if (retire_log.size() <= k || retire_log[k] - retire_log[k-1] !== exp_gap[k]) begin
                failures++;
                $display("FAIL branch_gap%0d: got=%0d required %0d", k,
                         (retire_log.size() > k) ? retire_log[k] - retire_log[k-1] : -1, exp_gap[k]);
            end
        end
        checks++;
        if (exp_writes.size() !== 0) begin
            failures++;
            $display("FAIL branch_pending: stores left=%0d required 0", exp_writes.size());
        end
    endtask

    task automatic test_illegal;
        int reqs = 0;
        begin_test(0);
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
        mem[2] = {6'h3F, 26'd0};
        rst_i   = 1'b0;
        start_i = 1'b1;
        for (int i = 0; i < 100 && halt_o !== 1'b1; i++) @(negedge clk);
        checks++;
        if (halt_o !== 1'b1 || illegal_o !== 1'b1 || pc_o !== 32'hC) begin
            failures++;
            $display("FAIL illegal_halt: halt=%b illegal=%b pc=%h required 1 1 0000000c", halt_o, illegal_o, pc_o);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req_o !== 1'b0) reqs++;
        end
        checks++;
        if (reqs !== 0 || halt_o !== 1'b1 || retire_log.size() !== 2) begin
            failures++;
            $display("FAIL illegal_sticky: reqs=%0d halt=%b retires=%0d required 0 1 2", reqs, halt_o, retire_log.size());
        end
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if (halt_o !== 1'b0 || illegal_o !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clear: halt=%b illegal=%b required 0 0", halt_o, illegal_o);
        end
    endtask

    task automatic test_pause;
        logic found = 1'b0;
        begin_test(1);
        mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd21);
        mem[1]  = enc_i(6'h23, 5'd0, 5'd4, 16'h0040);
        mem[2]  = enc_i(6'h2B, 5'd0, 5'd4, 16'h0048);
        mem[3]  = enc_i(6'h2B, 5'd0, 5'd1, 16'h004C);
        mem[16] = 32'h0000_0055;
        exp_writes = '{{32'h48, 32'h55}, {32'h4C, 32'd21}};
        rst_i   = 1'b0;
        start_i = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (mem_req_o === 1'b1 && mem_we_o === 1'b0 && mem_addr_o === 32'h40) found = 1'b1;
        end
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (!found || retire_log.size() !== 2 || mem_req_o !== 1'b0 || pc_o !== 32'h8 || halt_o !== 1'b0) begin
            failures++;
            $display("FAIL pause_idle: found=%b retires=%0d req=%b pc=%h halt=%b required 1 2 0 00000008 0",
                     found, retire_log.size(), mem_req_o, pc_o, halt_o);
        end
        start_i = 1'b1;
        for (int i = 0; i < 200 && halt_o !== 1'b1; i++) @(negedge clk);
        checks++;
        if (halt_o !== 1'b1 || retire_log.size() !== 4 || exp_writes.size() !== 0) begin
            failures++;
            $display("FAIL pause_resume: halt=%b retires=%0d stores left=%0d required 1 4 0",
                     halt_o, retire_log.size(), exp_writes.size());
        end
    endtask

    task automatic test_reset_mid_fetch;
        begin_test(3);
        mem[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
        mem[1] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0050);
        exp_writes = '{{32'h50, 32'd0}};
        rst_i   = 1'b0;
        start_i = 1'b1;
        for (int i = 0; i < 20 && mem_req_o !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b0 || pc_o !== 32'd0 || retire_o !== 1'b0 || retire_log.size() !== 0) begin
            failures++;
            $display("FAIL rst_mid_fetch: req=%b pc=%h retire=%b retires=%0d required 0 00000000 0 0",
                     mem_req_o, pc_o, retire_o, retire_log.size());
        end
        rst_i = 1'b0;
        for (int i = 0; i < 200 && halt_o !== 1'b1; i++) @(negedge clk);
        checks++;
        if (halt_o !== 1'b1 || retire_log.size() !== 2 || exp_writes.size() !== 0) begin
            failures++;
            $display("FAIL rst_zero_reg: halt=%b retires=%0d stores left=%0d required 1 2 0",
                     halt_o, retire_log.size(), exp_writes.size());
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_wait();
        test_branch();
        test_illegal();
        test_pause();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
